// File: rtl/pass_through_arb_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the pass-through arbiter.
package pass_through_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int unsigned DataWidthDef = 8;
  localparam int unsigned NReqDef      = 4;
  localparam int unsigned BurstLenDef  = 4;

  // Widest supported requester set; the helper works at this width.
  localparam int unsigned MaxReq = 16;
  localparam int unsigned IdxW   = 4;
  localparam int unsigned PickW  = IdxW + 1;

  // First set bit of req at or after ptr, wrapping modulo n. Returns {found, idx}.
  function automatic logic [PickW-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                               input logic [IdxW-1:0]   ptr,
                                               input logic [PickW-1:0]  n);
    logic            found;
    logic [IdxW-1:0] idx;
    logic [PickW-1:0] pos;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < MaxReq; k++) begin
      pos = {1'b0, ptr} + PickW'(k);
      if (pos >= n) pos = pos - n;
      if (!found && (PickW'(k) < n) && req[pos[IdxW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IdxW-1:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate / priority-encode / unrotate: first requester at or after ptr.
module rr_priority_pick
  import pass_through_arb_pkg::*;
#(
  parameter int unsigned n_req_g = NReqDef,
  parameter int unsigned idx_w_g = $clog2(n_req_g)
) (
  input  logic [n_req_g-1:0] req,
  input  logic [idx_w_g-1:0] ptr,
  output logic               found,
  output logic [idx_w_g-1:0] idx
);

  logic [PickW-1:0] w_pick;

  // Pick is done at the package's maximum width; unused request bits are zero.
  assign w_pick = rr_pick(MaxReq'(req), IdxW'(ptr), PickW'(n_req_g));
  assign found  = w_pick[IdxW];
  assign idx    = w_pick[idx_w_g-1:0];

  if (idx_w_g < IdxW) begin : g_hi
    // High index bits are always zero because indices never reach n_req_g.
    logic w_unused_hi;
    assign w_unused_hi = |w_pick[IdxW-1:idx_w_g];
  end

endmodule

// File: rtl/pass_through_rr_arbiter.sv
// Round-robin arbiter with bounded bursts feeding one registered a/b -> x/y stage.
module pass_through_rr_arbiter
  import pass_through_arb_pkg::*;
#(
  parameter int unsigned data_width_g = DataWidthDef,
  parameter int unsigned n_req_g      = NReqDef,
  parameter int unsigned burst_len_g  = BurstLenDef
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [n_req_g-1:0]                req_valid_in,
  output logic [n_req_g-1:0]                req_ready_out,
  input  logic [n_req_g*data_width_g-1:0]   a_in,
  input  logic [n_req_g*data_width_g-1:0]   b_in,
  output logic [data_width_g-1:0]           x_out,
  output logic [data_width_g-1:0]           y_out,
  output logic [$clog2(n_req_g)-1:0]        src_out,
  output logic                              valid_out,
  input  logic                              ready_in
);

  localparam int unsigned IW = $clog2(n_req_g);
  localparam int unsigned BW = $clog2(burst_len_g + 1);

  arb_state_t r_state, w_state_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [BW-1:0] r_burst, w_burst_nxt;

  logic [data_width_g-1:0] r_x, r_y;
  logic [IW-1:0]           r_src;
  logic                    r_valid;

  logic                    w_slot_free;
  logic                    w_owner_cont;
  logic [IW-1:0]           w_owner_inc;
  logic [IW-1:0]           w_pick_ptr;
  logic                    w_found;
  logic [IW-1:0]           w_idx;
  logic                    w_accept;
  logic [IW-1:0]           w_sel;
  logic [data_width_g-1:0] w_a, w_b;

  // Reset gates the slot so nothing is offered ready while rst_n is low.
  assign w_slot_free  = (!r_valid || ready_in) && rst_n;
  assign w_owner_inc  = (r_owner == IW'(n_req_g - 1)) ? '0 : r_owner + IW'(1);
  assign w_owner_cont = (r_state == ARB_BURST) && req_valid_in[r_owner] &&
                        (r_burst < BW'(burst_len_g));
  // On burst end the search starts just past the old owner, same cycle.
  assign w_pick_ptr   = (r_state == ARB_BURST) ? w_owner_inc : r_ptr;

  rr_priority_pick #(
    .n_req_g (n_req_g),
    .idx_w_g (IW)
  ) u_pick (
    .req   (req_valid_in),
    .ptr   (w_pick_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // Next-state, grant selection and burst accounting; everything freezes on stall.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_burst_nxt = r_burst;
    w_accept    = 1'b0;
    w_sel       = r_owner;
    if (w_slot_free) begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            w_accept    = 1'b1;
            w_sel       = w_idx;
            w_owner_nxt = w_idx;
            w_burst_nxt = BW'(1);
            w_state_nxt = ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (w_owner_cont) begin
            w_accept    = 1'b1;
            w_sel       = r_owner;
            w_burst_nxt = r_burst + BW'(1);
          end else begin
            w_ptr_nxt = w_owner_inc;
            if (w_found) begin
              w_accept    = 1'b1;
              w_sel       = w_idx;
              w_owner_nxt = w_idx;
              w_burst_nxt = BW'(1);
            end else begin
              w_burst_nxt = '0;
              w_state_nxt = ARB_IDLE;
            end
          end
        end
        default: w_state_nxt = ARB_IDLE;
      endcase
    end
  end

  // One-hot ready to the granted requester only.
  always_comb begin
    req_ready_out = '0;
    if (w_accept) req_ready_out[w_sel] = 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < n_req_g; i++) begin
      if (w_sel == IW'(i)) begin
        w_a = a_in[i*data_width_g +: data_width_g];
        w_b = b_in[i*data_width_g +: data_width_g];
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  // Output slot: load on accept, clear valid on drain, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_x     <= w_a;
      r_y     <= w_b;
      r_src   <= w_sel;
      r_valid <= 1'b1;
    end else if (ready_in) begin
      r_valid <= 1'b0;
    end
  end

  assign x_out     = r_x;
  assign y_out     = r_y;
  assign src_out   = r_src;
  assign valid_out = r_valid;

endmodule
